// File: rtl/rr_arb8_pkg.sv
// rr_arb8_pkg: constants and types shared by the rr_arb8 arbiter files.
//   NREQ             number of requesting clients
//   IDXW             width of a client index
//   CNTW             width of the saturating tenure counter
//   HOLD_MAX_DEFAULT default maximum tenure for the timeout build
//   state_e          arbiter state (IDLE, GRANT)
package rr_arb8_pkg;

   localparam int NREQ             = 8;
   localparam int IDXW             = 3;
   localparam int CNTW             = 8;
   localparam int HOLD_MAX_DEFAULT = 16;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

endpackage

// File: rtl/rr_arb8_if.sv
// rr_arb8_if: request/grant bundle between the clients and the arbiter.
//   req      client request vector (bit i = client i)
//   done     owner finished with the resource
//   gnt      one-hot grant, zero when no owner
//   gnt_idx  binary index of gnt, zero when no owner
//   gnt_vld  a grant is held
//   ptr      current highest-priority client (debug)
// Modports: master = client side, slave = arbiter side.
interface rr_arb8_if;
   import rr_arb8_pkg::*;

   logic [NREQ-1:0] req;
   logic            done;
   logic [NREQ-1:0] gnt;
   logic [IDXW-1:0] gnt_idx;
   logic            gnt_vld;
   logic [IDXW-1:0] ptr;

   modport master (
      output req, done,
      input  gnt, gnt_idx, gnt_vld, ptr
   );

   modport slave (
      input  req, done,
      output gnt, gnt_idx, gnt_vld, ptr
   );

endinterface

// File: rtl/onehot8_enc.sv
// onehot8_enc: combinational 8-bit one-hot to 3-bit binary encoder.
//   onehot  in  8  one-hot (or zero) vector
//   idx     out 3  index of the set bit, 3'd0 when the input is zero
module onehot8_enc
   import rr_arb8_pkg::*;
(
   input  logic [NREQ-1:0] onehot,
   output logic [IDXW-1:0] idx
);

   // OR of the indices of set bits; exact for a one-hot input.
   always_comb begin
      // NOTE: every combinational output gets a default before any
      // conditional assignment, so no path leaves it unassigned (no latch).
      idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (onehot[i]) idx = idx | IDXW'(i);
      end
   end

endmodule

// File: rtl/rr_arb8.sv
// rr_arb8: eight-requester round-robin arbiter with grant hold until release.
//   clk   in  rising-edge clock
//   rst   in  synchronous reset, active-high
//   bus   rr_arb8_if.slave: req, done in; gnt, gnt_idx, gnt_vld, ptr out
// Parameter HOLD_MAX (1..255): maximum tenure, used only when the macro
// RR_ARB8_TIMEOUT_EN is defined; otherwise a grant is held until done or
// until the owner drops its request.
module rr_arb8
   import rr_arb8_pkg::*;
#(
   parameter int HOLD_MAX = HOLD_MAX_DEFAULT
)(
   input  logic      clk,
   input  logic      rst,
   rr_arb8_if.slave  bus
);

   if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
      $error("rr_arb8: HOLD_MAX must be in 1..255");
   end

   state_e          state_q, state_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [IDXW-1:0] gnt_idx_q, gnt_idx_d;
   logic [IDXW-1:0] ptr_q, ptr_d;

   // Rotating-priority pick: rotate req right by ptr so the priority client
   // sits at bit 0, isolate the lowest set bit, rotate the result back.
   logic [NREQ-1:0]   req_rot, sel_rot, sel_gnt;
   logic [2*NREQ-1:0] req_dbl, sel_dbl;
   logic [IDXW-1:0]   sel_idx;

   assign req_dbl = {bus.req, bus.req} >> ptr_q;
   assign req_rot = req_dbl[NREQ-1:0];
   assign sel_rot = req_rot & (~req_rot + NREQ'(1));
   assign sel_dbl = {sel_rot, sel_rot} << ptr_q;
   assign sel_gnt = sel_dbl[2*NREQ-1:NREQ];

   onehot8_enc u_enc (
      .onehot (sel_gnt),
      .idx    (sel_idx)
   );

   logic release_now;

`ifdef RR_ARB8_TIMEOUT_EN
   logic [CNTW-1:0] cnt_q, cnt_d;
   localparam logic [CNTW-1:0] CNT_LAST = CNTW'(HOLD_MAX - 1);

   // Counter is 0 in the first grant cycle, so hitting HOLD_MAX-1 gives a
   // tenure of exactly HOLD_MAX cycles.
   assign release_now = bus.done | ~bus.req[gnt_idx_q] | (cnt_q == CNT_LAST);
`else
   assign release_now = bus.done | ~bus.req[gnt_idx_q];
`endif

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      gnt_idx_d = gnt_idx_q;
      ptr_d     = ptr_q;
`ifdef RR_ARB8_TIMEOUT_EN
      cnt_d     = cnt_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (|bus.req) begin
               gnt_d     = sel_gnt;
               gnt_idx_d = sel_idx;
               state_d   = GRANT;
`ifdef RR_ARB8_TIMEOUT_EN
               cnt_d     = '0;
`endif
            end
         end
         GRANT: begin
            if (release_now) begin
               gnt_d     = '0;
               gnt_idx_d = '0;
               // Natural 3-bit wrap takes 7 back to 0.
               ptr_d     = gnt_idx_q + IDXW'(1);
               state_d   = IDLE;
            end
`ifdef RR_ARB8_TIMEOUT_EN
            else if (cnt_q != '1) begin
               cnt_d = cnt_q + CNTW'(1);
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: reset is sampled only on the clock edge (synchronous) and it has
   // priority over every other input on that edge.
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so all flops
      // update from the same pre-edge values.
      if (rst) begin
         state_q   <= IDLE;
         gnt_q     <= '0;
         gnt_idx_q <= '0;
         ptr_q     <= '0;
`ifdef RR_ARB8_TIMEOUT_EN
         cnt_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         gnt_idx_q <= gnt_idx_d;
         ptr_q     <= ptr_d;
`ifdef RR_ARB8_TIMEOUT_EN
         cnt_q     <= cnt_d;
`endif
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.gnt_idx = gnt_idx_q;
   assign bus.gnt_vld = (state_q == GRANT);
   assign bus.ptr     = ptr_q;

endmodule

// File: tb/tb_rr_arb8.sv
// tb_rr_arb8: directed bench for rr_arb8. Each comparison checks the packed
// tuple {gnt, gnt_idx, gnt_vld, ptr} one time unit after a rising edge.
// The timeout scenario follows the RR_ARB8_TIMEOUT_EN build (HOLD_MAX=4).
module tb_rr_arb8;

   logic clk = 1'b0;
   logic rst;
   int   n_assert = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   rr_arb8_if u_if ();

   rr_arb8 #(.HOLD_MAX(4)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] gnt_e,
                        input logic [2:0] idx_e, input logic vld_e,
                        input logic [2:0] ptr_e);
      logic [14:0] obs, exp;
      obs = {u_if.gnt, u_if.gnt_idx, u_if.gnt_vld, u_if.ptr};
      exp = {gnt_e, idx_e, vld_e, ptr_e};
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got gnt=%h idx=%0d vld=%b ptr=%0d, want gnt=%h idx=%0d vld=%b ptr=%0d",
                tag, obs[14:7], obs[6:4], obs[3], obs[2:0],
                gnt_e, idx_e, vld_e, ptr_e);
      end
   endtask

   initial begin
      logic [7:0] oh;
      logic [2:0] k3;

      rst = 1'b1;
      u_if.req  = 8'h00;
      u_if.done = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check("reset", 8'h00, 3'd0, 1'b0, 3'd0);

      // Single requester, done after 3 grant cycles.
      u_if.req = 8'h01;
      tick(); check("t1_c1", 8'h01, 3'd0, 1'b1, 3'd0);
      tick(); check("t1_c2", 8'h01, 3'd0, 1'b1, 3'd0);
      tick(); check("t1_c3", 8'h01, 3'd0, 1'b1, 3'd0);
      u_if.done = 1'b1;
      tick(); check("t1_rel", 8'h00, 3'd0, 1'b0, 3'd1);
      u_if.done = 1'b0;
      u_if.req  = 8'h00;
      tick(); check("t1_idle", 8'h00, 3'd0, 1'b0, 3'd1);

      // All requesting: strict rotation 0..7,0 with a dead cycle between.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      u_if.req = 8'hFF;
      for (int k = 0; k < 9; k++) begin
         k3 = 3'(k);
         oh = 8'h01 << k3;
         tick(); check("rot_g1", oh, k3, 1'b1, k3);
         tick(); check("rot_g2", oh, k3, 1'b1, k3);
         u_if.done = 1'b1;
         tick(); check("rot_rel", 8'h00, 3'd0, 1'b0, k3 + 3'd1);
         u_if.done = 1'b0;
         if (k == 8) u_if.req = 8'h10;
      end

      // ptr=1, only client 4 -> grant 4, release moves ptr to 5.
      tick(); check("p_g4", 8'h10, 3'd4, 1'b1, 3'd1);
      u_if.done = 1'b1;
      tick(); check("p_rel4", 8'h00, 3'd0, 1'b0, 3'd5);
      u_if.done = 1'b0;
      u_if.req  = 8'h21;
      tick(); check("p_g5", 8'h20, 3'd5, 1'b1, 3'd5);
      u_if.done = 1'b1;
      tick(); check("p_rel5", 8'h00, 3'd0, 1'b0, 3'd6);
      u_if.done = 1'b0;
      tick(); check("p_g0", 8'h01, 3'd0, 1'b1, 3'd6);
      u_if.done = 1'b1;
      tick(); check("p_rel0", 8'h00, 3'd0, 1'b0, 3'd1);
      u_if.done = 1'b0;

      // Owner 3 withdraws while client 6 waits.
      u_if.req = 8'h48;
      tick(); check("w_g3", 8'h08, 3'd3, 1'b1, 3'd1);
      tick(); check("w_hold3", 8'h08, 3'd3, 1'b1, 3'd1);
      u_if.req = 8'h40;
      tick(); check("w_rel3", 8'h00, 3'd0, 1'b0, 3'd4);
      tick(); check("w_g6", 8'h40, 3'd6, 1'b1, 3'd4);
      tick(); check("w_hold6", 8'h40, 3'd6, 1'b1, 3'd4);

      // Reset mid-tenure overrides done/req on the same edge.
      rst       = 1'b1;
      u_if.done = 1'b1;
      u_if.req  = 8'hC0;
      tick(); check("r_reset", 8'h00, 3'd0, 1'b0, 3'd0);
      rst       = 1'b0;
      u_if.done = 1'b0;
      tick(); check("r_g6", 8'h40, 3'd6, 1'b1, 3'd0);
      u_if.done = 1'b1;
      tick(); check("r_rel6", 8'h00, 3'd0, 1'b0, 3'd7);
      u_if.req = 8'h00;
      // done with no owner is ignored.
      tick(); check("idle_done", 8'h00, 3'd0, 1'b0, 3'd7);
      u_if.done = 1'b0;

      // No done: timeout build rotates every HOLD_MAX cycles, otherwise
      // client 2 keeps the grant.
      u_if.req = 8'h0C;
`ifdef RR_ARB8_TIMEOUT_EN
      for (int c = 0; c < 4; c++) begin
         tick(); check("to_g2", 8'h04, 3'd2, 1'b1, 3'd7);
      end
      tick(); check("to_rel2", 8'h00, 3'd0, 1'b0, 3'd3);
      for (int c = 0; c < 4; c++) begin
         tick(); check("to_g3", 8'h08, 3'd3, 1'b1, 3'd3);
      end
      tick(); check("to_rel3", 8'h00, 3'd0, 1'b0, 3'd4);
      tick(); check("to_g2b", 8'h04, 3'd2, 1'b1, 3'd4);
`else
      for (int c = 0; c < 12; c++) begin
         tick(); check("hold_g2", 8'h04, 3'd2, 1'b1, 3'd7);
      end
`endif
      // Simultaneous done and owner drop: one release, ptr advances once.
      u_if.done = 1'b1;
      u_if.req  = 8'h00;
      tick();
`ifdef RR_ARB8_TIMEOUT_EN
      check("dual_rel", 8'h00, 3'd0, 1'b0, 3'd3);
`else
      check("dual_rel", 8'h00, 3'd0, 1'b0, 3'd3);
`endif
      u_if.done = 1'b0;
      tick(); check("dual_idle", 8'h00, 3'd0, 1'b0, 3'd3);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
